// File: rtl/fsm_seq_pkg.sv
// fsm_seq_pkg
// Shared types and helpers for the state-counter sequencer.
//   state_code_t : FSM output codes (start, odd, even, fin)
//   ctrl_state_t : controller states (IDLE, DRIVE)
//   next_input() : {q1,q2} that moves the FSM one step toward a target
package fsm_seq_pkg;

  typedef enum logic [1:0] {
    SC_START = 2'd0,
    SC_ODD   = 2'd1,
    SC_EVEN  = 2'd2,
    SC_FIN   = 2'd3
  } state_code_t;

  typedef enum logic {
    CTRL_IDLE  = 1'b0,
    CTRL_DRIVE = 1'b1
  } ctrl_state_t;

  localparam int ID_W   = 3;
  localparam int STEP_W = 3;

  // Returns {q1,q2}. The FSM only climbs start->odd->even->fin, so each
  // target just needs the input that advances from the current code.
  function automatic logic [1:0] next_input(input state_code_t cur,
                                            input state_code_t tgt);
    logic [1:0] q;
    q = 2'b00;
    case (tgt)
      SC_START: q = 2'b00;
      SC_ODD:   q = 2'b01;
      SC_EVEN:  q = (cur == SC_ODD) ? 2'b10 : 2'b01;
      SC_FIN: begin
        if (cur == SC_EVEN)     q = 2'b11;
        else if (cur == SC_ODD) q = 2'b10;
        else                    q = 2'b01;
      end
      default: q = 2'b00;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/fsm_seq_ctrl_rr_arb.sv
// fsm_seq_rr_arb
// Round-robin arbiter. Search starts at an internal pointer and wraps;
// when advance is high and a grant is made, the pointer moves one past
// the winner.
//   clk, reset    : clock, asynchronous active-high reset
//   i_req [N]     : request vector
//   i_advance     : commit the current grant (moves the pointer)
//   o_grant [N]   : one-hot grant (combinational)
//   o_grant_idx   : binary index of the granted requester
module fsm_seq_rr_arb #(
  parameter int N = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N-1:0]                        i_req,
  input  logic                                i_advance,
  output logic [N-1:0]                        o_grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] o_grant_idx
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] r_ptr;
  logic [IW:0]   w_pos;
  logic          w_found;

  // Candidate position is ptr+k reduced modulo N; the extra bit of w_pos
  // holds the unreduced sum.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_pos       = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_pos >= (IW+1)'(N)) begin
        w_pos = w_pos - (IW+1)'(N);
      end
      if (!w_found && i_req[w_pos[IW-1:0]]) begin
        w_found                  = 1'b1;
        o_grant[w_pos[IW-1:0]]   = 1'b1;
        o_grant_idx              = w_pos[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_advance && w_found) begin
      r_ptr <= (o_grant_idx == IW'(N - 1)) ? '0 : o_grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl
// Sequencer/arbiter in front of the two-input state-counter FSM. One
// client at a time (round-robin) gets its target code driven into the FSM
// through q1/q2; completion, step count and error are reported with a
// registered one-cycle done pulse.
// Optional feature: define FSM_SEQ_TIMEOUT_EN to abort a job with
// done_err=1 once MAX_STEPS inputs were applied without reaching target.
//   clk, reset      : clock, asynchronous active-high reset
//   i_req_valid [N] : per-client request
//   i_req_target    : per-client 2-bit target code, client i at [2i+1:2i]
//   o_req_ready [N] : one-hot accept (combinational, IDLE only)
//   o_q1, o_q2      : FSM inputs (combinational from i_count)
//   i_count         : current FSM output code
//   o_busy          : job in DRIVE
//   o_done_*        : registered completion pulse / id / err / steps
module fsm_seq_ctrl
  import fsm_seq_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_STEPS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [2*NUM_REQ-1:0]   i_req_target,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic                   o_q1,
  output logic                   o_q2,
  input  logic [1:0]             i_count,
  output logic                   o_busy,
  output logic                   o_done_valid,
  output logic [ID_W-1:0]        o_done_id,
  output logic                   o_done_err,
  output logic [STEP_W-1:0]      o_done_steps
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fsm_seq_ctrl: NUM_REQ must be 2..8");
  end
  if (MAX_STEPS < 1 || MAX_STEPS > 7) begin : g_bad_max_steps
    $error("fsm_seq_ctrl: MAX_STEPS must be 1..7");
  end

  ctrl_state_t        r_state, w_state_next;
  state_code_t        r_target;
  logic [ID_W-1:0]    r_id;
  logic [STEP_W-1:0]  r_steps, w_steps_next;
  logic               w_accept, w_finish, w_timeout;
  logic [1:0]         w_q;
  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0]      w_grant_idx;

  logic               r_done_valid, r_done_err;
  logic [ID_W-1:0]    r_done_id;
  logic [STEP_W-1:0]  r_done_steps;

  fsm_seq_rr_arb #(.N(NUM_REQ)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .i_req       (i_req_valid),
    .i_advance   (w_accept),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  always_comb begin
    w_state_next = r_state;
    w_q          = 2'b00;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    w_timeout    = 1'b0;
    w_steps_next = r_steps;
    case (r_state)
      CTRL_IDLE: begin
        // q stays 00 here so the FSM is back at start when DRIVE begins.
        if (|i_req_valid) begin
          w_accept     = 1'b1;
          w_state_next = CTRL_DRIVE;
        end
      end
      CTRL_DRIVE: begin
        if (i_count == r_target) begin
          w_finish     = 1'b1;
          w_state_next = CTRL_IDLE;
        end
`ifdef FSM_SEQ_TIMEOUT_EN
        else if (r_steps == STEP_W'(MAX_STEPS)) begin
          w_finish     = 1'b1;
          w_timeout    = 1'b1;
          w_state_next = CTRL_IDLE;
        end
`endif
        else begin
          w_q          = next_input(state_code_t'(i_count), r_target);
          // Saturates so an unreachable target cannot wrap the count.
          w_steps_next = (r_steps == 3'd7) ? r_steps : r_steps + 3'd1;
        end
      end
      default: w_state_next = CTRL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= CTRL_IDLE;
      r_target     <= SC_START;
      r_id         <= '0;
      r_steps      <= '0;
      r_done_valid <= 1'b0;
      r_done_id    <= '0;
      r_done_err   <= 1'b0;
      r_done_steps <= '0;
    end else begin
      r_state      <= w_state_next;
      r_steps      <= w_accept ? '0 : w_steps_next;
      r_done_valid <= w_finish;
      if (w_accept) begin
        r_target <= state_code_t'(i_req_target[{w_grant_idx, 1'b0} +: 2]);
        r_id     <= ID_W'(w_grant_idx);
      end
      if (w_finish) begin
        r_done_id    <= r_id;
        r_done_err   <= w_timeout;
        r_done_steps <= r_steps;
      end
    end
  end

  assign o_req_ready  = (r_state == CTRL_IDLE) ? w_grant : '0;
  assign {o_q1, o_q2} = w_q;
  assign o_busy       = (r_state == CTRL_DRIVE);
  assign o_done_valid = r_done_valid;
  assign o_done_id    = r_done_id;
  assign o_done_err   = r_done_err;
  assign o_done_steps = r_done_steps;

endmodule

// File: doc/fsm_seq_ctrl.md
# fsm_seq_ctrl

Sequencer and arbiter in front of the two-input state-counter FSM (states start=0, odd=1, even=2, fin=3; inputs q1/q2; output count). Up to NUM_REQ clients each request a target count value. The block grants one client at a time, round-robin. It drives q1/q2 cycle by cycle from the observed count until the FSM reaches the target, then reports completion, step count and error status to the winning client.

## Interface
- NUM_REQ, 4: number of requesting clients, 2..8.
- MAX_STEPS, 4: step limit before a job is flagged as an error, 1..7. Used only with FSM_SEQ_TIMEOUT_EN.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-client request.
- req_target  in  NUM_REQ x 2  per-client target state code.
- req_ready  out  NUM_REQ  one-hot accept. Combinational; at most one bit high.
- q1, q2  out  1 each  drive to the FSM inputs. Combinational (Mealy).
- count  in  2  current FSM output.
- busy  out  1  high while a job is in DRIVE.
- done_valid  out  1  one-cycle registered completion pulse.
- done_id  out  3  index of the completing client.
- done_err  out  1  job terminated on step limit.
- done_steps  out  3  number of DRIVE cycles in which inputs were applied.

## Operation
- Controller states: IDLE, DRIVE.
- IDLE:
  - q1/q2 = 00, so the FSM settles to start.
  - If any req_valid is high, the round-robin winner gets req_ready=1 that cycle. Its target and id are latched, steps clear to 0, and the next state is DRIVE.
- Arbitration:
  - Search starts at pointer p (reset 0) and wraps modulo NUM_REQ.
  - After a grant to client i, p = (i+1) mod NUM_REQ.
  - Grants occur only in IDLE.
- DRIVE, evaluated each cycle on the current count:
  - count == target: q=00, assert done (err=0), return to IDLE. Steps are not incremented.
  - Otherwise q1/q2 = next_input(count, target) and steps increments.
- next_input:
  - target start: 00.
  - target odd: 01.
  - target even: from odd 10, otherwise 01.
  - target fin: from even 11, from odd 10, otherwise 01.
- Done outputs:
  - done_valid, done_id, done_err and done_steps are registered and valid in the cycle after the terminating DRIVE cycle.
  - done_valid is high for exactly one cycle.
  - done_id, done_err and done_steps hold their values until the next done.
- A new request may be accepted in the same cycle as done_valid, because the controller is already in IDLE.
- Reset values: IDLE, p=0, busy=0, done_valid=0, done_id=0, done_err=0, done_steps=0, q=00, req_ready=0.
- Reset during DRIVE aborts the job. No done is issued; the client must re-request.
- req_target is sampled only at accept. Later changes have no effect on the job in flight.

## Timing
- Accept cycle A always drives 00, so DRIVE begins at A+1 with the FSM in start.
- Steps per target: start=0, odd=1, even=2, fin=3.
- done_valid asserts at A+2+steps.
- Minimum spacing between consecutive accepts: steps+2 cycles.
- Combinational paths count->q1/q2 and req_valid->req_ready are intended. No register sits on them.

## Configuration
- FSM_SEQ_TIMEOUT_EN defined:
  - In DRIVE, if count != target and steps == MAX_STEPS, the controller asserts done with err=1 and done_steps=MAX_STEPS, drives q=00 and returns to IDLE.
- FSM_SEQ_TIMEOUT_EN undefined:
  - There is no limit; DRIVE continues until count == target.
  - done_err is tied 0.
  - The steps counter saturates at 7.

## Structure
- Package fsm_seq_pkg holds:
  - the state-code enum (start, odd, even, fin);
  - the controller state enum (IDLE, DRIVE);
  - the next_input function.
- Sub-module fsm_seq_rr_arb: parameterised round-robin arbiter with inputs req and advance, output one-hot grant, and pointer kept internally.
- The FSM itself is not instantiated. The bench or parent connects q1/q2/count.

## Test plan
- Client 0 targets fin from reset, FSM connected:
  - req_ready[0]=1 at A.
  - q sequence 01, 10, 11 at A+1..A+3.
  - done_valid at A+5 with id=0, steps=3, err=0.
- Client 2 targets start: done_valid at A+2, steps=0, q=00 throughout.
- All four clients valid simultaneously with targets odd/even/fin/start:
  - Grants in order 0, 1, 2, 3.
  - Each later grant coincides with the previous done_valid.
- Clients 1 and 3 held valid continuously: grants alternate 1, 3, 1, 3.
- Reset asserted at A+2 of a fin job:
  - busy=0 and q=00 immediately; no done_valid.
  - After release, client 0 wins first.
- With FSM_SEQ_TIMEOUT_EN, count tied to 00 and target even:
  - Four cycles of q=01.
  - done_valid at A+6 with err=1, steps=4.
